ram_loader: RTL
===============

# ram_loader

Serial program loader for the fpg8 CPU. It receives a framed byte stream on a UART RX line, assembles 16-bit words big-endian, and writes them into the 4096-word RAM starting at address 0. While a load is in progress it holds the CPU in reset. It is the writer side of the RAM image that the CPU later fetches and executes, replacing the fixed INIT_FILE image for field reprogramming.

## Interface

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200); must be ≥ 4
- ADDR_WIDTH, 12, RAM address width
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  input  1  system clock (undivided board clock, not the one-shot clock)
- reset  input  1  asynchronous, active-high; clears all state
- rx  input  1  UART receive line, idle high, 8N1, LSB first; asynchronous to clk
- load_en  input  1  level; 1 = loader armed, 0 = abort and return to IDLE
- ram_w_en  output  1  one-cycle RAM write strobe
- ram_addr  output  ADDR_WIDTH  RAM write address
- ram_w_data  output  16  RAM write data
- cpu_hold  output  1  1 while a frame is being received; ORed into CPU reset at top level
- busy  output  1  1 in any state other than IDLE, DONE and ERROR
- done  output  1  sticky 1 after a complete successful frame
- frame_err  output  1  sticky 1 after a bad stop bit or illegal length
- word_count  output  ADDR_WIDTH+1  number of words written in the current or last frame

## Operation

- The rx input passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Byte receiver:
  - In RX_IDLE, a synchronized falling edge starts a bit counter.
  - At CLKS_PER_BIT/2 the start bit is re-sampled; if it is high, the receiver returns to RX_IDLE (glitch rejection).
  - The 8 data bits are then sampled every CLKS_PER_BIT clocks, LSB first, followed by the stop bit.
  - Stop bit = 1: byte_valid pulses for 1 cycle with the byte.
  - Stop bit = 0: byte_err pulses for 1 cycle instead.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then 2×N data bytes (high byte first per word). N = {LEN_HI, LEN_LO} and must satisfy 1 ≤ N ≤ 2^ADDR_WIDTH.
- Frame FSM states and transitions:
  - IDLE: outputs quiet. load_en=1 → WAIT_SYNC.
  - WAIT_SYNC: a byte equal to SYNC_BYTE → LEN_HI and clears word_count, done and frame_err. Other bytes are ignored.
  - LEN_HI → LEN_LO.
  - LEN_LO: N = 0 or N > 4096 → ERROR; otherwise → DATA_HI.
  - DATA_HI: latches the high byte → DATA_LO.
  - DATA_LO: latches the low byte → WRITE.
  - WRITE: asserts ram_w_en for 1 cycle with ram_addr = word_count[ADDR_WIDTH-1:0]. word_count then increments. If word_count reaches N → DONE, else → DATA_HI.
  - DONE: done=1. load_en=0 → IDLE (done stays set). A new SYNC_BYTE is not accepted until the FSM has passed through IDLE.
  - ERROR: frame_err=1. load_en=0 → IDLE (frame_err stays set).
- A byte_err in any state from LEN_HI through DATA_LO → ERROR. A byte_err in WAIT_SYNC is ignored.
- Deasserting load_en in any state → IDLE next cycle, with no further writes. RAM keeps the words already written. done and frame_err are unchanged.
- cpu_hold = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE and ERROR; 0 in IDLE, WAIT_SYNC and DONE.
- The address wraps only by construction: the last legal address is 4095, reached when N = 4096; word_count then reads 4096.

## Timing

- Reset values: ram_w_en=0, ram_addr=0, ram_w_data=0, cpu_hold=0, busy=0, done=0, frame_err=0, word_count=0. FSM in IDLE, receiver in RX_IDLE.
- rx to internal edge latency: 2 clocks (synchronizer).
- byte_valid is asserted on the cycle after the stop-bit sample point, about 9.5 bit times after the start edge.
- ram_w_en is asserted the cycle after the byte_valid of the low byte. ram_addr and ram_w_data are registered and valid on that same cycle, and hold until the next write.
- Back-to-back bytes at full line rate are sustained; WRITE takes 1 cycle, far less than one bit time.
- An asynchronous reset mid-frame drops all outputs immediately. Any partial RAM contents are left as they are.

## Test plan

- Basic load: with load_en=1, send A5 00 02 12 34 AB CD → exactly two ram_w_en pulses, (addr 0, 16'h1234) then (addr 1, 16'hABCD). After that, done=1, word_count=2, cpu_hold=0.
- Glitch and garbage: a 0.25-bit low pulse on rx, then bytes 00 FF, then a valid frame of length 1 → no pulse from the glitch, garbage ignored in WAIT_SYNC, a single write at addr 0.
- Framing error: in the 2nd data byte, force the stop bit to 0 → frame_err=1, ERROR state, cpu_hold=1, no write for that word. Dropping load_en → IDLE, cpu_hold=0.
- Illegal length: send A5 00 00, and separately A5 10 01 → ERROR immediately after LEN_LO, no writes.
- Abort: drop load_en after 3 of 5 words → exactly 3 writes (addr 0..2), IDLE on the next cycle, busy=0, done=0.
- Full memory: N=4096 (A5 10 00) → final write at addr 4095, word_count=4096, done=1, no write to addr 0 beyond the first.

Source files
------------

// File: rtl/ram_loader.sv
// Serial program loader: receives an 8N1 UART frame (SYNC, LEN_HI, LEN_LO, data words
// big-endian), writes the words into RAM from address 0 and holds the CPU in reset while loading.
module ram_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          ADDR_WIDTH   = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  load_en,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_w_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_LEN = 17'(2 ** ADDR_WIDTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_SYNC = 4'd1;
  localparam logic [3:0] ST_LEN_HI    = 4'd2;
  localparam logic [3:0] ST_LEN_LO    = 4'd3;
  localparam logic [3:0] ST_DATA_HI   = 4'd4;
  localparam logic [3:0] ST_DATA_LO   = 4'd5;
  localparam logic [3:0] ST_WRITE     = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_ERROR     = 4'd8;

  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]       r_rx_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_byte_err;

  // Byte receiver. r_shift holds the last byte until the next byte's data bits arrive.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_byte_valid <= 1'b0;
      r_byte_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_bit_cnt == HALF_M1) begin
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_bit_cnt == FULL_M1) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (r_bit_cnt == FULL_M1) begin
            r_bit_cnt    <= '0;
            r_rx_state   <= RX_IDLE;
            r_byte_valid <= r_rx_sync;
            r_byte_err   <= !r_rx_sync;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  logic [3:0]            r_state;
  logic [7:0]            r_len_hi, r_data_hi;
  logic [ADDR_WIDTH:0]   r_len, r_word_count;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [15:0]           r_ram_w_data;
  logic                  r_w_en, r_done, r_frame_err;
  logic [15:0]           w_len;
  logic                  w_len_ok;
  logic [ADDR_WIDTH:0]   w_next_count;

  assign w_len        = {r_len_hi, r_shift};
  assign w_len_ok     = (w_len != 16'd0) && ({1'b0, w_len} <= MAX_LEN);
  assign w_next_count = r_word_count + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_len_hi     <= '0;
      r_data_hi    <= '0;
      r_len        <= '0;
      r_word_count <= '0;
      r_ram_addr   <= '0;
      r_ram_w_data <= '0;
      r_w_en       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      // The strobe is already out in WRITE, so the count follows it even if aborting now.
      if (r_state == ST_WRITE) r_word_count <= w_next_count;
      if (!load_en) begin
        r_state <= ST_IDLE;
      end else if (r_byte_err && (r_state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO})) begin
        r_state     <= ST_ERROR;
        r_frame_err <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT_SYNC;
          ST_WAIT_SYNC: begin
            if (r_byte_valid && r_shift == SYNC_BYTE) begin
              r_state      <= ST_LEN_HI;
              r_word_count <= '0;
              r_done       <= 1'b0;
              r_frame_err  <= 1'b0;
            end
          end
          ST_LEN_HI: begin
            if (r_byte_valid) begin
              r_len_hi <= r_shift;
              r_state  <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (r_byte_valid) begin
              if (w_len_ok) begin
                r_len   <= w_len[ADDR_WIDTH:0];
                r_state <= ST_DATA_HI;
              end else begin
                r_state     <= ST_ERROR;
                r_frame_err <= 1'b1;
              end
            end
          end
          ST_DATA_HI: begin
            if (r_byte_valid) begin
              r_data_hi <= r_shift;
              r_state   <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            if (r_byte_valid) begin
              r_ram_w_data <= {r_data_hi, r_shift};
              r_ram_addr   <= r_word_count[ADDR_WIDTH-1:0];
              r_w_en       <= 1'b1;
              r_state      <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (w_next_count == r_len) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
          ST_DONE:  r_state <= ST_DONE;
          default:  r_state <= ST_ERROR;
        endcase
      end
    end
  end

  assign ram_w_en   = r_w_en;
  assign ram_addr   = r_ram_addr;
  assign ram_w_data = r_ram_w_data;
  assign done       = r_done;
  assign frame_err  = r_frame_err;
  assign word_count = r_word_count;
  assign cpu_hold   = r_state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_WRITE, ST_ERROR};
  assign busy       = !(r_state inside {ST_IDLE, ST_DONE, ST_ERROR});

endmodule
